// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: states, opcodes, mux selects, ALU ops.
package mc_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_PC4 = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_ALU = 1'b1;
  localparam logic OP1_RS1  = 1'b0;
  localparam logic OP1_PC   = 1'b1;
  localparam logic OP2_RS2  = 1'b0;
  localparam logic OP2_IMM  = 1'b1;

  function automatic logic opcode_legal(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: opcode_legal = 1'b1;
      default:                               opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// ALU operation decode from opcode/funct3/funct7. Address-forming and branch-target
// instructions all use ADD; only register-register ops may select SUB.
module mc_ctrl_fsm_alu_dec
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [3:0] alu_ctrl
);

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    alu_ctrl = ALU_ADD;
    if (opcode == OPC_R || opcode == OPC_IMM) begin
      case (funct3)
        3'b000:  alu_ctrl = (opcode == OPC_R && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_ctrl = ALU_SLL;
        3'b010:  alu_ctrl = ALU_SLT;
        3'b011:  alu_ctrl = ALU_SLTU;
        3'b100:  alu_ctrl = ALU_XOR;
        // srai shares the funct7[5] marker with sra, so shifts honour it for both forms
        3'b101:  alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
        3'b110:  alu_ctrl = ALU_OR;
        default: alu_ctrl = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for an RV32I datapath with a shared memory port.
// Only the state and retire counter are registered; every strobe is decoded from the state.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int MEM_TO_MAX = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             run,
  input  logic [31:0]      inst,
  input  logic             br_taken,
  input  logic             mem_ready,
  output logic             mem_re,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             alu_op1_sel,
  output logic             alu_op2_sel,
  output logic [3:0]       alu_ctrl,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] inst_cnt
);

  if (MEM_TO_MAX != 0) begin : g_mem_timeout_unsupported
    $error("mc_ctrl_fsm: MEM_TO_MAX must be 0, memory timeouts are not implemented");
  end

  state_t     cur, nxt;
  logic       retire;
  logic       re, we, asel, irwe, pcwe, rfwe;
  logic [1:0] pcs;
  logic [6:0] opc;
  logic       is_r, is_load, is_store, is_branch, is_lui, is_auipc, is_jal, is_jalr;
  logic       unused_inst_bits;

  assign opc              = inst[6:0];
  assign is_r             = (opc == OPC_R);
  assign is_load          = (opc == OPC_LOAD);
  assign is_store         = (opc == OPC_STORE);
  assign is_branch        = (opc == OPC_BRANCH);
  assign is_lui           = (opc == OPC_LUI);
  assign is_auipc         = (opc == OPC_AUIPC);
  assign is_jal           = (opc == OPC_JAL);
  assign is_jalr          = (opc == OPC_JALR);
  assign unused_inst_bits = ^{inst[24:15], inst[11:7]};

  mc_ctrl_fsm_alu_dec u_alu_dec (
    .opcode   (opc),
    .funct3   (inst[14:12]),
    .funct7   (inst[31:25]),
    .alu_ctrl (alu_ctrl)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur      <= S_IF;
      inst_cnt <= '0;
    end else begin
      cur <= nxt;
      if (retire) inst_cnt <= inst_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt    = cur;
    retire = 1'b0;
    re     = 1'b0;
    we     = 1'b0;
    asel   = ADDR_PC;
    irwe   = 1'b0;
    pcwe   = 1'b0;
    pcs    = PC_PLUS4;
    rfwe   = 1'b0;
    case (cur)
      S_IF: begin
        // the read request stays up every cycle until memory answers
        if (run) begin
          re = 1'b1;
          if (mem_ready) begin
            irwe = 1'b1;
            nxt  = S_ID;
          end
        end
      end
      S_ID: nxt = opcode_legal(opc) ? S_EX : S_HALT;
      S_EX: begin
        if (is_branch) begin
          pcwe   = 1'b1;
          pcs    = br_taken ? PC_BRANCH : PC_PLUS4;
          retire = 1'b1;
          nxt    = S_IF;
        end else if (is_load || is_store) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        asel = ADDR_ALU;
        if (is_store) we = 1'b1;
        else          re = 1'b1;
        if (mem_ready) begin
          if (is_store) begin
            pcwe   = 1'b1;
            retire = 1'b1;
            nxt    = S_IF;
          end else begin
            nxt = S_WB;
          end
        end
      end
      S_WB: begin
        rfwe   = 1'b1;
        pcwe   = 1'b1;
        pcs    = is_jal ? PC_BRANCH : (is_jalr ? PC_JALR : PC_PLUS4);
        retire = 1'b1;
        nxt    = S_IF;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IF;
    endcase
  end

  // Operand and write-back selects stay valid from EX through WB so the ALU result is stable.
  always_comb begin
    alu_op1_sel = OP1_RS1;
    alu_op2_sel = OP2_RS2;
    wb_sel      = WB_ALU;
    if (cur == S_EX || cur == S_MEM || cur == S_WB) begin
      if (is_auipc || is_jal || is_branch) alu_op1_sel = OP1_PC;
      if (!is_r)                           alu_op2_sel = OP2_IMM;
      if (is_jal || is_jalr)               wb_sel = WB_PC4;
      else if (is_load)                    wb_sel = WB_MEM;
      else if (is_lui)                     wb_sel = WB_IMM;
    end
  end

  // rstn gates the strobes directly so an aborted access drops without waiting for a clock.
  assign mem_re       = rstn & re;
  assign mem_we       = rstn & we;
  assign mem_addr_sel = rstn & asel;
  assign ir_we        = rstn & irwe;
  assign pc_we        = rstn & pcwe;
  assign pc_sel       = rstn ? pcs : PC_PLUS4;
  assign rf_we        = rstn & rfwe;
  assign halted       = (cur == S_HALT);
  assign state        = cur;

endmodule
